// File: rtl/test_pkg.sv
// Shared types and constants for the simulation test controller.
// Verdict states, tohost defaults and a width helper.
package test_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam int PASS_CODE = 1;
  localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_03F0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/test_ctrl_tohost_mon.sv
// Per-core tohost snoop: decodes a data-memory write into
// pass / fail hits and the reported failure code.
module tohost_mon
  import test_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR =
    ADDR_W'(TOHOST_DEFAULT)
) (
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              hit_pass,
  output logic              hit_fail,
  output logic [DATA_W-2:0] code
);

  logic hit;
  logic is_pass;

  assign hit      = we && (addr == TOHOST_ADDR);
  assign is_pass  = wdata == DATA_W'(PASS_CODE);
  // Even values are not results; only odd values decide.
  assign hit_pass = hit && is_pass;
  assign hit_fail = hit && wdata[0] && !is_pass;
  assign code     = wdata[DATA_W-1:1];

endmodule

// File: rtl/test_ctrl.sv
// Test controller: core reset sequencing, run-cycle budget
// and tohost verdict latching for one or more cores.
module test_ctrl
  import test_pkg::*;
#(
  parameter int NCORES       = 1,
  parameter int RESET_CYCLES = 1,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 16,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR =
    ADDR_W'(TOHOST_DEFAULT),
  localparam int FC_W =
    (NCORES > 1) ? clog2(NCORES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        mem_we,
  input  logic [NCORES*ADDR_W-1:0] mem_addr,
  input  logic [NCORES*DATA_W-1:0] mem_wdata,
  output logic                     core_rst,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [FC_W-1:0]          fail_core,
  output logic [DATA_W-2:0]        fail_code,
  output logic [NCORES-1:0]        pass_mask,
  output logic [CNT_W-1:0]         cycles
);

  localparam int HC_W = clog2(RESET_CYCLES) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [HC_W-1:0]   hold;
  logic [NCORES-1:0] hit_pass;
  logic [NCORES-1:0] hit_fail;
  logic [NCORES-1:0] pass_nxt;
  logic [DATA_W-2:0] codes [NCORES];
  logic              any_fail;
  logic [FC_W-1:0]   fidx;
  logic [DATA_W-2:0] fcode;

  for (genvar i = 0; i < NCORES; i++) begin : g_mon
    tohost_mon #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_mon (
      .we       (mem_we[i]),
      .addr     (mem_addr[i*ADDR_W +: ADDR_W]),
      .wdata    (mem_wdata[i*DATA_W +: DATA_W]),
      .hit_pass (hit_pass[i]),
      .hit_fail (hit_fail[i]),
      .code     (codes[i])
    );
  end

  assign any_fail = |hit_fail;
  assign pass_nxt = pass_mask | hit_pass;

  // Scan downward so the lowest failing core wins.
  always_comb begin
    fidx  = '0;
    fcode = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (hit_fail[i]) begin
        fidx  = FC_W'(i);
        fcode = codes[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RESET: begin
        if (hold == HC_W'(RESET_CYCLES - 1))
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (any_fail)
          state_nxt = ST_FAIL;
        else if (&pass_nxt)
          state_nxt = ST_PASS;
        else if (cycles == CNT_W'(TIMEOUT - 1))
          state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RESET;
      hold      <= '0;
      cycles    <= '0;
      pass_mask <= '0;
      fail_core <= '0;
      fail_code <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RESET)
        hold <= hold + 1'b1;
      if (state == ST_RUN) begin
        cycles    <= cycles + 1'b1;
        pass_mask <= pass_nxt;
        if (any_fail) begin
          fail_core <= fidx;
          fail_code <= fcode;
        end
      end
    end
  end

  // Pure decodes of the state register.
  assign core_rst = state != ST_RUN;
  assign pass     = state == ST_PASS;
  assign fail     = state == ST_FAIL;
  assign timeout  = state == ST_TIMEOUT;
  assign done     = pass | fail | timeout;

endmodule

// File: tb/tb_test_ctrl.sv
// Directed bench for test_ctrl: a 1-core and a 4-core
// instance checked against hand-computed verdicts.
module tb_test_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        we1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] wd1 = '0;
  logic        core_rst1, done1, pass1, fail1, tmo1;
  logic [0:0]  fcore1;
  logic [30:0] fcode1;
  logic [0:0]  pmask1;
  logic [15:0] cyc1;

  logic [3:0]   we4 = '0;
  logic [127:0] addr4 = '0;
  logic [127:0] wd4 = '0;
  logic         core_rst4, done4, pass4, fail4, tmo4;
  logic [1:0]   fcore4;
  logic [30:0]  fcode4;
  logic [3:0]   pmask4;
  logic [15:0]  cyc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  test_ctrl #(
    .NCORES       (1),
    .RESET_CYCLES (3),
    .TIMEOUT      (64)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (we1),
    .mem_addr  (addr1),
    .mem_wdata (wd1),
    .core_rst  (core_rst1),
    .done      (done1),
    .pass      (pass1),
    .fail      (fail1),
    .timeout   (tmo1),
    .fail_core (fcore1),
    .fail_code (fcode1),
    .pass_mask (pmask1),
    .cycles    (cyc1)
  );

  test_ctrl #(
    .NCORES       (4),
    .RESET_CYCLES (1),
    .TIMEOUT      (64)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (we4),
    .mem_addr  (addr4),
    .mem_wdata (wd4),
    .core_rst  (core_rst4),
    .done      (done4),
    .pass      (pass4),
    .fail      (fail4),
    .timeout   (tmo4),
    .fail_core (fcore4),
    .fail_code (fcode4),
    .pass_mask (pmask4),
    .cycles    (cyc4)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic wr1(
    input logic [31:0] a,
    input logic [31:0] d
  );
    addr1 = a;
    wd1   = d;
    we1   = 1'b1;
    step(1);
    we1   = 1'b0;
  endtask

  task automatic wr4(
    input logic [3:0]  we,
    input logic [31:0] d0,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] d3
  );
    addr4 = {4{32'h0000_03F0}};
    wd4   = {d3, d2, d1, d0};
    we4   = we;
    step(1);
    we4   = '0;
  endtask

  initial begin
    // Reset values while rst is held
    #12;
    chk("rst_core_rst", core_rst1, 1);
    chk("rst_done", done1, 0);
    chk("rst_cycles", cyc1, 0);
    chk("rst_mask4", pmask4, 0);
    chk("rst_fcode4", fcode4, 0);

    // Reset hold: core_rst for exactly 3 edges
    step(1);
    rst = 1'b1;
    step(1);
    chk("hold_e0", core_rst1, 1);
    step(1);
    chk("hold_e1", core_rst1, 1);
    step(1);
    chk("hold_e2", core_rst1, 0);
    chk("hold_done", done1, 0);
    chk("hold_cycles", cyc1, 0);
    chk("hold_mask", pmask1, 0);

    // Pass in RUN cycle 10, later failure ignored
    step(10);
    wr1(32'h3F0, 32'd1);
    chk("p1_done", done1, 1);
    chk("p1_pass", pass1, 1);
    chk("p1_cycles", cyc1, 11);
    chk("p1_core_rst", core_rst1, 1);
    wr1(32'h3F0, 32'd7);
    chk("p1_keep_pass", pass1, 1);
    chk("p1_keep_fail", fail1, 0);
    chk("p1_keep_cyc", cyc1, 11);

    // Fail code 21 after ignored writes
    restart();
    step(3);
    wr1(32'h3EC, 32'h2B);
    wr1(32'h3F0, 32'd2);
    chk("f1_ign_done", done1, 0);
    chk("f1_ign_cyc", cyc1, 2);
    wr1(32'h3F0, 32'h2B);
    chk("f1_fail", fail1, 1);
    chk("f1_pass", pass1, 0);
    chk("f1_code", fcode1, 21);
    chk("f1_core", fcore1, 0);
    chk("f1_cycles", cyc1, 3);

    // Four cores pass in two groups
    restart();
    step(1);
    chk("p4_run", core_rst4, 0);
    wr4(4'b0111, 1, 1, 1, 0);
    chk("p4_partial_done", done4, 0);
    chk("p4_partial_mask", pmask4, 4'b0111);
    wr4(4'b1000, 0, 0, 0, 1);
    chk("p4_pass", pass4, 1);
    chk("p4_mask", pmask4, 4'b1111);
    chk("p4_cycles", cyc4, 2);

    // Simultaneous failures: lowest index wins
    restart();
    step(1);
    wr4(4'b1011, 1, 5, 0, 5);
    chk("f4_fail", fail4, 1);
    chk("f4_pass", pass4, 0);
    chk("f4_core", fcore4, 1);
    chk("f4_code", fcode4, 2);

    // Timeout with no tohost write
    restart();
    step(3);
    step(63);
    chk("to_before_done", done1, 0);
    chk("to_before_cyc", cyc1, 63);
    step(1);
    chk("to_timeout", tmo1, 1);
    chk("to_done", done1, 1);
    chk("to_cycles", cyc1, 64);

    // Pass on the last budget cycle beats timeout
    restart();
    step(3);
    step(63);
    wr1(32'h3F0, 32'd1);
    chk("tp_pass", pass1, 1);
    chk("tp_timeout", tmo1, 0);
    chk("tp_cycles", cyc1, 64);

    // Asynchronous reset mid-RUN
    restart();
    step(3);
    step(5);
    chk("ar_pre_cyc", cyc1, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_run_cyc", cyc1, 0);
    chk("ar_run_core_rst", core_rst1, 1);
    rst = 1'b1;
    step(3);
    chk("ar_restart", core_rst1, 0);
    step(4);
    chk("ar_restart_cyc", cyc1, 4);

    // Asynchronous reset from a terminal state
    wr1(32'h3F0, 32'h2B);
    chk("ar_term_fail", fail1, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_term_fail0", fail1, 0);
    chk("ar_term_done", done1, 0);
    chk("ar_term_code", fcode1, 0);
    chk("ar_term_cyc", cyc1, 0);
    chk("ar_term_core_rst", core_rst1, 1);
    rst = 1'b1;
    step(2);
    chk("ar_term_hold", core_rst1, 1);
    step(1);
    chk("ar_term_run", core_rst1, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/test_ctrl.md
# test_ctrl

Synthesizable self-checking test controller for CPU simulation and FPGA bring-up. It sequences reset to one or more CPU cores, counts run cycles against a budget, and snoops each core's data-memory write port for a result written to a dedicated "tohost" address. It latches a final PASS, FAIL or TIMEOUT verdict. Benches stop on `done`, so they no longer rely on a fixed-length run.

## Interface
Parameters:
- `NCORES`, 1: number of monitored cores (1..8).
- `RESET_CYCLES`, 1: cycles `core_rst` is held after `rst` deasserts (≥1).
- `TIMEOUT`, 64: run-cycle budget (≥1, < 2^CNT_W).
- `CNT_W`, 16: cycle counter width.
- `ADDR_W`, 32 / `DATA_W`, 32: memory-port widths.
- `TOHOST_ADDR`, 32'h0000_03F0: result address.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `mem_we` in NCORES: per-core data-memory write enable.
- `mem_addr` in NCORES*ADDR_W: per-core write address. Core i occupies bits [i*ADDR_W +: ADDR_W].
- `mem_wdata` in NCORES*DATA_W: per-core write data, packed the same way.
- `core_rst` out 1: active-high reset to all cores.
- `done` out 1: verdict latched.
- `pass` / `fail` / `timeout` out 1 each: one-hot verdict, valid while `done`=1.
- `fail_core` out clog2(NCORES) (min 1): index of the failing core.
- `fail_code` out DATA_W-1: value `wdata>>1` from the failing write.
- `pass_mask` out NCORES: cores that have reported pass.
- `cycles` out CNT_W: RUN cycles elapsed.

## Operation
- States: RESET → RUN → {PASS, FAIL, TIMEOUT}. The verdict states are terminal and are left only by `rst`.
- RESET:
  - `core_rst`=1 and a hold counter counts from 0.
  - At count RESET_CYCLES-1 the FSM moves to RUN and `core_rst` drops on the same edge.
- RUN:
  - `cycles` increments every cycle.
  - A tohost hit for core i is `mem_we[i]` & `mem_addr_i`==TOHOST_ADDR.
  - wdata==1 sets `pass_mask[i]`. Repeat passes are idempotent.
  - wdata odd and ≠1 is a failure with code `wdata>>1`.
  - wdata even, including 0, is ignored.
  - Writes to any other address are ignored.
- Verdict priority within one cycle: FAIL > PASS > TIMEOUT.
  - Simultaneous failures: the lowest core index wins.
  - PASS requires `pass_mask`, including this cycle's hits, to equal all ones.
  - TIMEOUT fires when `cycles`==TIMEOUT-1 and there is no FAIL or PASS in that cycle.
- A core that has already passed and then writes a failure code causes FAIL.
- Terminal states:
  - `core_rst`=1, which freezes the cores.
  - `cycles`, `pass_mask`, `fail_core` and `fail_code` hold their values.
  - All snooped writes are ignored.
- `rst` asserted in any state returns to RESET immediately, asynchronously.

## Timing
- Reset values: `core_rst`=1, `done`=`pass`=`fail`=`timeout`=0, `fail_core`=0, `fail_code`=0, `pass_mask`=0, `cycles`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A deciding write sampled at edge N gives `done` and the verdict visible after edge N. That is 1-cycle latency, with `core_rst` rising on the same edge.
- `rst` released before edge 0 puts RUN's first cycle after edge RESET_CYCLES-1.
- `cycles` equals the number of RUN cycles completed, including the deciding cycle.
  - Example: TIMEOUT=64 gives `cycles`=64 at timeout.

## Structure
- Package `test_pkg`:
  - state enum (RESET, RUN, PASS, FAIL, TIMEOUT)
  - `PASS_CODE`=1
  - default `TOHOST_ADDR`
  - `clog2` helper
- Sub-module `tohost_mon`, one instance per core:
  - combinational decode of `hit_pass`, `hit_fail`, `code`.
  - The top level holds the FSM, counters and lowest-index priority encoder.

## Test plan
- NCORES=1, RESET_CYCLES=3: release `rst` → `core_rst`=1 for exactly 3 edges, then 0; all other outputs stay at reset values.
- NCORES=1: write 1 to 0x3F0 in RUN cycle 10 → `done`=`pass`=1, `cycles`=11, `core_rst`=1; a later write of 7 leaves the verdict unchanged.
- NCORES=1: write 0x2B (code 21) to 0x3F0 → `fail`=1, `fail_code`=21, `fail_core`=0. Writes of 0x2B to 0x3EC and of 2 to 0x3F0 beforehand are ignored.
- NCORES=4:
  - cores 0–2 pass, then core 3 passes → PASS with `pass_mask`=4'b1111.
  - Separate run: cores 1 and 3 write 5 in the same cycle as core 0 writes 1 → FAIL, `fail_core`=1, `fail_code`=2.
- TIMEOUT=64, no tohost write → `timeout`=1 with `cycles`=64. A pass write in RUN cycle 63 instead gives PASS, not TIMEOUT.
- Assert `rst` mid-RUN and again in a terminal state → all outputs return to reset values asynchronously; the sequence restarts cleanly after release.
